// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: pipeline hazard sources in, register strobes and status out.
// The pipeline side drives as master; the controller sits on the slave modport.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
) ();
    logic             IDEX_MemRead_i;
    logic [4:0]       IDEX_RTaddr_i;
    logic [4:0]       IFID_RSaddr_i;
    logic [4:0]       IFID_RTaddr_i;
    logic             Branch_taken_i;
    logic             Mem_req_i;
    logic             Mem_ack_i;
    logic             PC_write_o;
    logic             IFID_write_o;
    logic             IFID_flush_o;
    logic             IDEX_write_o;
    logic             IDEX_bubble_o;
    logic             EXMEM_write_o;
    logic             EXMEM_flush_o;
    logic             MEMWB_bubble_o;
    logic             ready_o;
    logic             err_o;
    logic [CNT_W-1:0] stall_cnt_o;

    modport master (
        output IDEX_MemRead_i, IDEX_RTaddr_i, IFID_RSaddr_i, IFID_RTaddr_i,
               Branch_taken_i, Mem_req_i, Mem_ack_i,
        input  PC_write_o, IFID_write_o, IFID_flush_o, IDEX_write_o, IDEX_bubble_o,
               EXMEM_write_o, EXMEM_flush_o, MEMWB_bubble_o, ready_o, err_o, stall_cnt_o
    );

    modport slave (
        input  IDEX_MemRead_i, IDEX_RTaddr_i, IFID_RSaddr_i, IFID_RTaddr_i,
               Branch_taken_i, Mem_req_i, Mem_ack_i,
        output PC_write_o, IFID_write_o, IFID_flush_o, IDEX_write_o, IDEX_bubble_o,
               EXMEM_write_o, EXMEM_flush_o, MEMWB_bubble_o, ready_o, err_o, stall_cnt_o
    );
endinterface

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline stall/flush controller; strobes are combinational (0 cycles) from state + inputs.
// Backpressure: a pending memory access (req without ack) freezes every pipeline register.
module hazard_ctrl #(
    parameter int BOOT_CYCLES = 4,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic          clk_i,
    input  logic          start_i,
    hazard_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {BOOT, RUN, MEM_WAIT, HALT} state_t;

    localparam int BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1) + 1;

    // Strobe order: PC_w, IFID_w, IFID_flush, IDEX_w, IDEX_bubble, EXMEM_w, EXMEM_flush, MEMWB_bubble
    localparam logic [7:0] S_BOOT   = 8'b0010_1011;
    localparam logic [7:0] S_FREEZE = 8'b0000_0001;
    localparam logic [7:0] S_BRANCH = 8'b1111_1110;
    localparam logic [7:0] S_LOAD   = 8'b0001_1100;
    localparam logic [7:0] S_NORMAL = 8'b1101_0100;

    state_t            state;
    logic [BOOT_W-1:0] boot_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              err;
    logic [CNT_W-1:0]  stall_cnt;
    logic [7:0]        strb;
    logic              mstall;
    logic              load_use;
    logic              active;

    assign mstall   = bus.Mem_req_i & ~bus.Mem_ack_i;
    assign load_use = bus.IDEX_MemRead_i && (bus.IDEX_RTaddr_i != 5'd0) &&
                      ((bus.IDEX_RTaddr_i == bus.IFID_RSaddr_i) ||
                       (bus.IDEX_RTaddr_i == bus.IFID_RTaddr_i));
    assign active   = (state == RUN) || (state == MEM_WAIT);

    always_comb begin
        strb = S_NORMAL;
        case (state)
            BOOT:    strb = S_BOOT;
            HALT:    strb = S_FREEZE;
            default: begin
                // A branch held in the frozen EX/MEM stage is honoured once the freeze lifts.
                if (mstall)                  strb = S_FREEZE;
                else if (bus.Branch_taken_i) strb = S_BRANCH;
                else if (load_use)           strb = S_LOAD;
                else                         strb = S_NORMAL;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            state     <= BOOT;
            boot_cnt  <= '0;
            wait_cnt  <= '0;
            err       <= 1'b0;
            stall_cnt <= '0;
        end else begin
            case (state)
                BOOT: begin
                    if (boot_cnt == BOOT_W'(BOOT_CYCLES - 1)) state <= RUN;
                    else                                      boot_cnt <= boot_cnt + 1'b1;
                end
                RUN: begin
                    if (mstall) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= WAIT_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (mstall) begin
                        if ((MEM_TIMEOUT != 0) && (wait_cnt == WAIT_W'(MEM_TIMEOUT))) begin
                            state <= HALT;
                            err   <= 1'b1;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end else begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end
                end
                default: state <= HALT;
            endcase

            if (active && !strb[7] && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign bus.PC_write_o     = strb[7];
    assign bus.IFID_write_o   = strb[6];
    assign bus.IFID_flush_o   = strb[5];
    assign bus.IDEX_write_o   = strb[4];
    assign bus.IDEX_bubble_o  = strb[3];
    assign bus.EXMEM_write_o  = strb[2];
    assign bus.EXMEM_flush_o  = strb[1];
    assign bus.MEMWB_bubble_o = strb[0];
    assign bus.ready_o        = (state != BOOT);
    assign bus.err_o          = err;
    assign bus.stall_cnt_o    = stall_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: expected output vectors are queued as stimulus is applied
// and popped at the following falling edge, where the combinational strobes are settled.
module tb_hazard_ctrl;
    localparam int CNT_W = 4;
    localparam int W     = 10 + CNT_W;

    // PC_w, IFID_w, IFID_flush, IDEX_w, IDEX_bubble, EXMEM_w, EXMEM_flush, MEMWB_bubble
    localparam logic [7:0] P_BOOT = 8'b0010_1011;
    localparam logic [7:0] P_NORM = 8'b1101_0100;
    localparam logic [7:0] P_LU   = 8'b0001_1100;
    localparam logic [7:0] P_BR   = 8'b1111_1110;
    localparam logic [7:0] P_FRZ  = 8'b0000_0001;

    logic clk   = 1'b0;
    logic start = 1'b0;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(CNT_W)) hif ();

    hazard_ctrl #(
        .BOOT_CYCLES(4),
        .MEM_TIMEOUT(4),
        .CNT_W(CNT_W)
    ) dut (
        .clk_i   (clk),
        .start_i (start),
        .bus     (hif)
    );

    logic [W-1:0] obs;
    assign obs = {hif.PC_write_o, hif.IFID_write_o, hif.IFID_flush_o, hif.IDEX_write_o,
                  hif.IDEX_bubble_o, hif.EXMEM_write_o, hif.EXMEM_flush_o, hif.MEMWB_bubble_o,
                  hif.ready_o, hif.err_o, hif.stall_cnt_o};

    logic [W-1:0]     sb[$];
    logic [W-1:0]     exp_v;
    logic [7:0]       pat;
    logic [CNT_W-1:0] exp_cnt = '0;
    int               n_cmp   = 0;
    int               n_bad   = 0;

    task automatic set_in(input logic mr, input logic [4:0] rtx, input logic [4:0] rs,
                          input logic [4:0] rtd, input logic br, input logic req,
                          input logic ack);
        hif.IDEX_MemRead_i = mr;
        hif.IDEX_RTaddr_i  = rtx;
        hif.IFID_RSaddr_i  = rs;
        hif.IFID_RTaddr_i  = rtd;
        hif.Branch_taken_i = br;
        hif.Mem_req_i      = req;
        hif.Mem_ack_i      = ack;
    endtask

    task automatic push_exp(input logic [7:0] p, input logic rdy, input logic er);
        sb.push_back({p, rdy, er, exp_cnt});
    endtask

    // Step past the rising edge; the bench's counter model follows stalled edges, saturating.
    task automatic advance(input bit counts);
        @(posedge clk);
        #1;
        if (counts && (exp_cnt != {CNT_W{1'b1}})) exp_cnt = exp_cnt + 1'b1;
    endtask

    task automatic idle();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        idle();
        start = 1'b0;
        @(posedge clk);
        #1;
        push_exp(P_BOOT, 1'b0, 1'b0);
        @(negedge clk);
        exp_v = sb.pop_front();
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL reset_hold got=%b exp=%b", obs, exp_v);
        end
        @(posedge clk);
        #1;
        start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) push_exp(P_BOOT, 1'b0, 1'b0);
            else       push_exp(P_NORM, 1'b1, 1'b0);
            @(negedge clk);
            exp_v = sb.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL boot_seq[%0d] got=%b exp=%b", i, obs, exp_v);
            end
            advance(1'b0);
        end
    endtask

    task automatic test_load_use();
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: begin set_in(1'b1, 5'd5, 5'd3, 5'd4, 1'b0, 1'b0, 1'b0); pat = P_NORM; end
                1: begin set_in(1'b1, 5'd5, 5'd5, 5'd4, 1'b0, 1'b0, 1'b0); pat = P_LU;   end
                2: begin set_in(1'b1, 5'd5, 5'd3, 5'd5, 1'b0, 1'b0, 1'b0); pat = P_LU;   end
                3: begin set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0); pat = P_NORM; end
                default: begin set_in(1'b0, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0); pat = P_NORM; end
            endcase
            push_exp(pat, 1'b1, 1'b0);
            @(negedge clk);
            exp_v = sb.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL load_use[%0d] got=%b exp=%b", i, obs, exp_v);
            end
            advance(pat == P_LU);
        end
    endtask

    task automatic test_branch();
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: begin set_in(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0); pat = P_BR;   end
                1: begin set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0); pat = P_BR;   end
                2: begin set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0); pat = P_FRZ;  end
                3: begin set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1); pat = P_BR;   end
                4: begin set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1); pat = P_NORM; end
                default: begin idle(); pat = P_NORM; end
            endcase
            push_exp(pat, 1'b1, 1'b0);
            @(negedge clk);
            exp_v = sb.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL branch[%0d] got=%b exp=%b", i, obs, exp_v);
            end
            advance(pat == P_FRZ);
        end
    endtask

    task automatic test_mem_wait();
        for (int i = 0; i < 10; i++) begin
            if (i < 3)       begin set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0); pat = P_FRZ;  end
            else if (i == 3) begin set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1); pat = P_NORM; end
            else if (i == 4) begin idle(); pat = P_NORM; end
            else if (i < 7)  begin set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0); pat = P_FRZ;  end
            else if (i == 7) begin idle(); pat = P_NORM; end
            else if (i == 8) begin set_in(1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b1, 1'b0); pat = P_FRZ;  end
            else             begin set_in(1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0); pat = P_LU;   end
            push_exp(pat, 1'b1, 1'b0);
            @(negedge clk);
            exp_v = sb.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL mem_wait[%0d] got=%b exp=%b", i, obs, exp_v);
            end
            advance(pat != P_NORM);
        end
        idle();
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 8; i++) begin
            if (i < 6)       set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
            else if (i == 6) idle();
            else             set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1);
            push_exp(P_FRZ, 1'b1, (i >= 5));
            @(negedge clk);
            exp_v = sb.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL timeout[%0d] got=%b exp=%b", i, obs, exp_v);
            end
            advance(i < 5);
        end
        // Asynchronous reset out of HALT, observed before any clock edge.
        #2;
        start   = 1'b0;
        exp_cnt = '0;
        push_exp(P_BOOT, 1'b0, 1'b0);
        #1;
        exp_v = sb.pop_front();
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL halt_async_reset got=%b exp=%b", obs, exp_v);
        end
        idle();
        @(posedge clk);
        #1;
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_exp(P_BOOT, 1'b0, 1'b0);
            @(negedge clk);
            exp_v = sb.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL reboot[%0d] got=%b exp=%b", i, obs, exp_v);
            end
            advance(1'b0);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 19; i++) begin
            if (i < 18) begin set_in(1'b1, 5'd9, 5'd9, 5'd1, 1'b0, 1'b0, 1'b0); pat = P_LU;   end
            else        begin idle(); pat = P_NORM; end
            push_exp(pat, 1'b1, 1'b0);
            @(negedge clk);
            exp_v = sb.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL saturate[%0d] got=%b exp=%b", i, obs, exp_v);
            end
            advance(pat == P_LU);
        end
        @(negedge clk);
        n_cmp++;
        if (hif.stall_cnt_o !== 4'd15) begin
            n_bad++;
            $display("FAIL saturate_final got=%0d exp=15", hif.stall_cnt_o);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline.
- Drives the write-enable, flush and bubble strobes of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Sources: load-use hazards between ID and EX, taken branches resolved in MEM, and multi-cycle data-memory accesses (req/ack).
- Also sequences post-reset boot, detects memory timeouts and counts stall cycles.

Parameters:
BOOT_CYCLES, 4, clock edges held in BOOT after reset release (legal range >=1)
MEM_TIMEOUT, 255, consecutive frozen cycles before HALT (0 = timeout disabled)
CNT_W, 16, width of stall_cnt_o

Ports:
clk_i  in  1  clock, rising edge
start_i  in  1  asynchronous active-low reset
IDEX_MemRead_i  in  1  instruction in EX is a load
IDEX_RTaddr_i  in  5  load destination register in EX
IFID_RSaddr_i  in  5  rs of instruction in ID
IFID_RTaddr_i  in  5  rt of instruction in ID
Branch_taken_i  in  1  branch in MEM resolved taken
Mem_req_i  in  1  MEM stage issuing a data-memory read/write
Mem_ack_i  in  1  data memory completes the access this cycle
PC_write_o  out  1  PC load enable
IFID_write_o  out  1  IF/ID load enable
IFID_flush_o  out  1  IF/ID clear to NOP
IDEX_write_o  out  1  ID/EX load enable
IDEX_bubble_o  out  1  zero ID/EX control fields on load
EXMEM_write_o  out  1  EX/MEM load enable
EXMEM_flush_o  out  1  zero EX/MEM control fields on load
MEMWB_bubble_o  out  1  zero MEM/WB control fields on load
ready_o  out  1  controller out of BOOT
err_o  out  1  sticky memory-timeout error
stall_cnt_o  out  CNT_W  saturating stall-cycle counter

Behaviour:
- FSM states: BOOT, RUN, MEM_WAIT, HALT. Reset (start_i low, asynchronous) forces BOOT, boot_cnt=0, wait_cnt=0, err_o=0, stall_cnt_o=0.
- BOOT outputs, also the reset values:
  - PC_write_o, IFID_write_o, IDEX_write_o, EXMEM_write_o = 0.
  - IFID_flush_o, IDEX_bubble_o, EXMEM_flush_o, MEMWB_bubble_o = 1.
  - ready_o = 0.
- BOOT: boot_cnt increments each edge; the edge with boot_cnt==BOOT_CYCLES-1 moves to RUN. Exactly BOOT_CYCLES edges are spent in BOOT.
- Strobe outputs are combinational from state plus current inputs. State, counters, err_o and stall_cnt_o are registered. ready_o = (state != BOOT).
- mstall = Mem_req_i & ~Mem_ack_i.
- Priority in RUN/MEM_WAIT: freeze > branch flush > load-use > normal.
  - Freeze (mstall=1): all four *_write_o=0, MEMWB_bubble_o=1, all flush/bubble strobes otherwise 0.
  - Branch (Branch_taken_i=1, no freeze): PC_write_o=1, IFID_write_o=1, IDEX_write_o=1, EXMEM_write_o=1, IFID_flush_o=1, IDEX_bubble_o=1, EXMEM_flush_o=1, MEMWB_bubble_o=0.
  - Load-use (IDEX_MemRead_i=1, IDEX_RTaddr_i!=0, IDEX_RTaddr_i==IFID_RSaddr_i or IFID_RTaddr_i): PC_write_o=0, IFID_write_o=0, IDEX_bubble_o=1, all other writes 1, flushes 0.
  - Normal: all *_write_o=1, all flush/bubble=0.
- Branch during freeze is not lost: EX/MEM is frozen, so Branch_taken_i persists and is honoured on the release cycle.
- Transitions:
  - RUN with mstall -> MEM_WAIT, wait_cnt<=1.
  - MEM_WAIT with mstall: if MEM_TIMEOUT!=0 and wait_cnt==MEM_TIMEOUT -> HALT, err_o<=1; else wait_cnt++.
  - MEM_WAIT with Mem_ack_i=1, or with Mem_req_i dropping without ack -> RUN. This cycle uses RUN priority rules; wait_cnt<=0.
- Ack in the same cycle as req: no freeze, zero latency.
- HALT: freeze outputs, held until reset. err_o stays 1; ready_o=1.
- stall_cnt_o: +1 on each edge in RUN/MEM_WAIT where PC_write_o==0. Saturates at 2^CNT_W-1. Not counted in BOOT/HALT.
- Reset asserted mid-stall or in HALT returns to BOOT immediately and clears err_o and counters.

Test Plan:
- Reset release, BOOT_CYCLES=4 -> exactly 4 edges with ready_o=0 and flush strobes=1; 5th cycle shows all writes=1, all strobes=0, stall_cnt_o=0.
- Load-use, IDEX_MemRead_i=1, IDEX_RTaddr_i=5, IFID_RSaddr_i=5 -> one cycle PC_write_o=0, IFID_write_o=0, IDEX_bubble_o=1; stall_cnt_o becomes 1. Same with RTaddr=0 -> no stall.
- Branch_taken_i=1 together with a load-use match -> branch wins: IFID_flush_o=1, IDEX_bubble_o=1, EXMEM_flush_o=1, PC_write_o=1.
- Mem_req_i=1, Mem_ack_i low for 3 cycles then high -> 3 frozen cycles with MEMWB_bubble_o=1; ack cycle normal; stall_cnt_o +3; state back to RUN.
- MEM_TIMEOUT=4, Mem_ack_i never asserted -> err_o rises after the 5th frozen cycle's edge and stays 1 with outputs frozen; start_i pulse low -> err_o=0, state BOOT.
- 2^CNT_W+2 stall cycles with CNT_W=4 -> stall_cnt_o saturates at 15.
